// File: rtl/lr_useq.sv
// lr_useq: microcode address sequencer with call/return stack, conditional
// branch, opcode dispatch, interrupt entry at fetch boundaries, HALT and a
// memory-stall hold.
// Optional performance counters are built when LR_USEQ_PERF_EN is defined.
module lr_useq #(
  parameter int UADDR_W     = 10,
  parameter int STACK_DEPTH = 4,
  parameter int COND_N      = 8,
  parameter int COND_W      = 3,
  parameter int RESET_VEC   = 0,
  parameter int IRQ_VEC     = 16'h3f0,
  parameter int DISP_BASE   = 16'h100,
  parameter int DISP_SHIFT  = 1
) (
  input  logic                               clock4,
  input  logic                               reset,
  input  logic                               stall,
  input  logic [2:0]                         seq_op,
  input  logic [UADDR_W-1:0]                 target,
  input  logic [COND_W-1:0]                  cond_sel,
  input  logic                               cond_inv,
  input  logic [COND_N-1:0]                  cond,
  input  logic [7:0]                         opcode,
  input  logic                               irq,
  output logic [UADDR_W-1:0]                 uaddr,
  output logic                               irq_ack,
  output logic                               halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_depth,
  output logic                               stk_err,
  output logic [31:0]                        perf_insn,
  output logic [31:0]                        perf_stall
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [UADDR_W-1:0] RESET_LO = UADDR_W'(RESET_VEC);
  localparam logic [UADDR_W-1:0] IRQ_LO   = UADDR_W'(IRQ_VEC);
  localparam logic [UADDR_W-1:0] DISP_LO  = UADDR_W'(DISP_BASE);
  localparam logic [SP_W-1:0]    SP_FULL  = SP_W'(STACK_DEPTH);

  localparam logic [2:0] OP_SEQ   = 3'd0;
  localparam logic [2:0] OP_JMP   = 3'd1;
  localparam logic [2:0] OP_BR    = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_DISP  = 3'd5;
  localparam logic [2:0] OP_FETCH = 3'd6;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t               state, state_nx;
  logic [UADDR_W-1:0]   uaddr_nx, uaddr_inc, disp_addr;
  logic [UADDR_W+7:0]   disp_wide;
  logic [SP_W-1:0]      sp_nx;
  logic                 err_nx, push, cond_bit;
  logic [IDX_W-1:0]     push_idx, pop_idx;
  logic [UADDR_W-1:0]   stack [STACK_DEPTH];

  assign uaddr_inc = uaddr + UADDR_W'(1);
  assign disp_wide = {{UADDR_W{1'b0}}, opcode} << DISP_SHIFT;
  assign disp_addr = DISP_LO + disp_wide[UADDR_W-1:0];
  assign push_idx  = IDX_W'(sp_depth);
  assign pop_idx   = IDX_W'(sp_depth - SP_W'(1));
  assign halted    = (state == S_HALT);

  // Condition mux; select values with no matching input read as 0.
  always_comb begin
    cond_bit = 1'b0;
    for (int i = 0; i < COND_N; i++) begin
      if (cond_sel == COND_W'(i)) cond_bit = cond[i];
    end
  end

  // Next-state, next-address, stack control and interrupt acknowledge.
  always_comb begin
    state_nx = state;
    uaddr_nx = uaddr;
    sp_nx    = sp_depth;
    err_nx   = stk_err;
    push     = 1'b0;
    irq_ack  = 1'b0;
    if (!stall && !reset) begin
      if (state == S_HALT) begin
        if (irq) begin
          state_nx = S_RUN;
          uaddr_nx = IRQ_LO;
          irq_ack  = 1'b1;
        end
      end else begin
        case (seq_op)
          OP_SEQ: uaddr_nx = uaddr_inc;
          OP_JMP: uaddr_nx = target;
          OP_BR:  uaddr_nx = (cond_bit ^ cond_inv) ? target : uaddr_inc;
          OP_CALL: begin
            uaddr_nx = target;
            if (sp_depth == SP_FULL) begin
              err_nx = 1'b1;
            end else begin
              push  = 1'b1;
              sp_nx = sp_depth + SP_W'(1);
            end
          end
          OP_RET: begin
            if (sp_depth == '0) begin
              uaddr_nx = RESET_LO;
              err_nx   = 1'b1;
            end else begin
              uaddr_nx = stack[pop_idx];
              sp_nx    = sp_depth - SP_W'(1);
            end
          end
          OP_DISP: uaddr_nx = disp_addr;
          OP_FETCH: begin
            if (irq) begin
              uaddr_nx = IRQ_LO;
              irq_ack  = 1'b1;
            end else begin
              uaddr_nx = disp_addr;
            end
          end
          default: state_nx = S_HALT;
        endcase
      end
    end
  end

  // Control state: FSM, address register, stack pointer and sticky error.
  always_ff @(posedge clock4) begin
    if (reset) begin
      state    <= S_RUN;
      uaddr    <= RESET_LO;
      sp_depth <= '0;
      stk_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      uaddr    <= uaddr_nx;
      sp_depth <= sp_nx;
      stk_err  <= err_nx;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clock4) begin
    if (push) stack[push_idx] <= uaddr_inc;
  end

`ifdef LR_USEQ_PERF_EN
  logic        insn_inc;
  logic [31:0] insn_cnt, stall_cnt;

  assign insn_inc = !stall && (state == S_RUN) &&
                    ((seq_op == OP_DISP) || ((seq_op == OP_FETCH) && !irq));

  // Instruction and stall-cycle counters, wrapping at 2^32.
  always_ff @(posedge clock4) begin
    if (reset) begin
      insn_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (insn_inc) insn_cnt  <= insn_cnt + 32'd1;
      if (stall)    stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_insn  = insn_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_insn  = '0;
  assign perf_stall = '0;
`endif

endmodule
